// File: rtl/exp_sum_accum_if.sv
// Handshake bundle between the exponential-term producer, the sum accumulator
// and the downstream log2 stage.
interface exp_sum_accum_if #(
  parameter int VEC_LEN = 64
);
  localparam int CNT_W = $clog2(VEC_LEN) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_x;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      sum_x;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  modport master (
    output in_valid, in_x, in_last, out_ready,
    input  in_ready, out_valid, sum_x, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_x, in_last, out_ready,
    output in_ready, out_valid, sum_x, out_cnt, out_ovf
  );
endinterface

// File: rtl/exp_sum_accum.sv
// Accumulates a vector of Q4.12 exponential terms into a non-zero Q4.12 sum for log2.
// Optional macro EXP_SUM_SAT_EN: saturate sum_x to 0xFFFF on overflow instead of wrapping.
module exp_sum_accum #(
  parameter int VEC_LEN = 64,
  parameter int ACC_W   = 22
) (
  input  logic           clk,
  input  logic           rst,
  exp_sum_accum_if.slave bus
);
  localparam int CNT_W = $clog2(VEC_LEN) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      sum_q, sum_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             ovf_q, ovf_d;
  logic             take;
  logic             close;
  logic             acc_big;

  // log2 cannot take zero, so a zero result (true or wrapped) becomes one LSB
  function automatic logic [15:0] fmt_sum(input logic [ACC_W-1:0] a);
    logic [15:0] r;
`ifdef EXP_SUM_SAT_EN
    if (|a[ACC_W-1:16]) begin
      r = 16'hFFFF;
    end else begin
      r = a[15:0];
    end
`else
    r = a[15:0];
`endif
    if (r == 16'h0000) begin
      r = 16'h0001;
    end else begin
      r = r;
    end
    return r;
  endfunction

  assign bus.in_ready  = rst || (state_q != ST_OUT);
  assign bus.out_valid = out_valid_q;
  assign bus.sum_x     = sum_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_ovf   = ovf_q;

  // Next-state, accumulation and result capture
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    out_cnt_d   = out_cnt_q;
    ovf_d       = ovf_q;
    take        = bus.in_valid && (state_q != ST_OUT);
    acc_sum     = acc_q + {{(ACC_W-16){1'b0}}, bus.in_x};
    cnt_inc     = cnt_q + CNT_W'(1);
    close       = bus.in_last || (cnt_inc == CNT_W'(VEC_LEN));
    acc_big     = |acc_sum[ACC_W-1:16];
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (take) begin
          acc_d = acc_sum;
          cnt_d = cnt_inc;
          if (close) begin
            state_d     = ST_OUT;
            out_valid_d = 1'b1;
            sum_d       = fmt_sum(acc_sum);
            out_cnt_d   = cnt_inc;
            ovf_d       = acc_big;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          acc_d       = {ACC_W{1'b0}};
          cnt_d       = {CNT_W{1'b0}};
          out_valid_d = 1'b0;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        acc_d       = {ACC_W{1'b0}};
        cnt_d       = {CNT_W{1'b0}};
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and result registers; reset wins over any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      sum_q       <= 16'h0000;
      out_cnt_q   <= {CNT_W{1'b0}};
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      out_cnt_q   <= out_cnt_d;
      ovf_q       <= ovf_d;
    end
  end
endmodule

// File: tb/tb_exp_sum_accum.sv
// Self-checking bench for exp_sum_accum: directed scenarios plus randomized vectors
// compared against an arithmetic reference of the vector sum.
module tb_exp_sum_accum;
  localparam int VEC_LEN = 64;
  localparam int CNT_W   = $clog2(VEC_LEN) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0] vec_x [0:1023];

  exp_sum_accum_if #(.VEC_LEN(VEC_LEN)) bus ();

  exp_sum_accum #(.VEC_LEN(VEC_LEN), .ACC_W(22)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic longint vec_total(input int n);
    longint t = 0;
    for (int i = 0; i < n; i++) t += vec_x[i];
    return t;
  endfunction

  function automatic logic [15:0] model_sum(input longint total);
    longint v;
`ifdef EXP_SUM_SAT_EN
    v = (total > 65535) ? 65535 : total;
`else
    v = total % 65536;
`endif
    if (v == 0) v = 1;
    return 16'(v);
  endfunction

  task automatic push_beats(input int n, input bit use_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_x     = 16'($urandom);
        bus.in_last  = 1'($urandom);
        @(posedge clk);
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_x     = vec_x[i];
      bus.in_last  = use_last && (i == n - 1);
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.sum_x, bus.out_cnt, bus.out_ovf} !== {1'b0, 16'h0000, {CNT_W{1'b0}}, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b s=%h c=%0d o=%b want all 0", bus.out_valid, bus.sum_x, bus.out_cnt, bus.out_ovf);
    end
  endtask

  task automatic test_four_beats();
    for (int i = 0; i < 4; i++) vec_x[i] = 16'h1000;
    push_beats(4, 1'b1, 1'b0);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL four_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.sum_x !== 16'h4000) begin n_bad++; $display("FAIL four_sum: got %h want 4000", bus.sum_x); end
    n_cmp++; if (bus.out_cnt !== CNT_W'(4) || bus.out_ovf !== 1'b0) begin n_bad++; $display("FAIL four_cnt_ovf: got %0d/%b want 4/0", bus.out_cnt, bus.out_ovf); end
    consume();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL four_release: got v=%b r=%b want 0/1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_single();
    vec_x[0] = 16'h0800;
    push_beats(1, 1'b1, 1'b0);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL single_out: got v=%b r=%b want 1/0", bus.out_valid, bus.in_ready); end
    n_cmp++; if (bus.sum_x !== 16'h0800 || bus.out_cnt !== CNT_W'(1)) begin n_bad++; $display("FAIL single_val: got %h/%0d want 0800/1", bus.sum_x, bus.out_cnt); end
    consume();
  endtask

  task automatic test_full_vector();
    logic [15:0] exp_s;
`ifdef EXP_SUM_SAT_EN
    exp_s = 16'hFFFF;
`else
    exp_s = 16'h0001;
`endif
    for (int i = 0; i < VEC_LEN; i++) vec_x[i] = 16'h1000;
    push_beats(VEC_LEN - 1, 1'b0, 1'b0);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL full_early: got %b want 0", bus.out_valid); end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = 16'h1000;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_cnt !== CNT_W'(VEC_LEN) || bus.out_ovf !== 1'b1) begin n_bad++; $display("FAIL full_cnt_ovf: got %0d/%b want %0d/1", bus.out_cnt, bus.out_ovf, VEC_LEN); end
    n_cmp++; if (bus.sum_x !== exp_s) begin n_bad++; $display("FAIL full_sum: got %h want %h", bus.sum_x, exp_s); end
    consume();
  endtask

  task automatic test_zeros();
    for (int i = 0; i < 3; i++) vec_x[i] = 16'h0000;
    push_beats(3, 1'b1, 1'b0);
    n_cmp++; if (bus.sum_x !== 16'h0001 || bus.out_ovf !== 1'b0 || bus.out_cnt !== CNT_W'(3)) begin
      n_bad++; $display("FAIL zeros: got %h/%b/%0d want 0001/0/3", bus.sum_x, bus.out_ovf, bus.out_cnt);
    end
    consume();
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_s;
    for (int i = 0; i < 3; i++) vec_x[i] = 16'($urandom_range(0, 16'h1000));
    exp_s = model_sum(vec_total(3));
    push_beats(3, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 16'($urandom);
      bus.in_last  = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.sum_x !== exp_s || bus.out_cnt !== CNT_W'(3) || bus.out_ovf !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_c%0d: got r=%b v=%b s=%h c=%0d want 0/1/%h/3", c, bus.in_ready, bus.out_valid, bus.sum_x, bus.out_cnt, exp_s);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release: got v=%b r=%b want 0/1", bus.out_valid, bus.in_ready); end
    bus.in_x    = 16'h0100;
    bus.in_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.sum_x !== 16'h0100 || bus.out_cnt !== CNT_W'(1)) begin
      n_bad++; $display("FAIL hold_next: got v=%b s=%h c=%0d want 1/0100/1", bus.out_valid, bus.sum_x, bus.out_cnt);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) vec_x[i] = 16'h0700;
    push_beats(2, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_cnt !== {CNT_W{1'b0}}) begin n_bad++; $display("FAIL rstmid_nout: got v=%b c=%0d want 0/0", bus.out_valid, bus.out_cnt); end
    for (int i = 0; i < 2; i++) vec_x[i] = 16'h0400;
    push_beats(2, 1'b1, 1'b0);
    n_cmp++; if (bus.sum_x !== 16'h0800 || bus.out_cnt !== CNT_W'(2)) begin n_bad++; $display("FAIL rstmid_next: got %h/%0d want 0800/2", bus.sum_x, bus.out_cnt); end
    // pending result dropped by reset even while out_ready is asserted
    rst = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rstout_ready: got %b want 1", bus.in_ready); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.sum_x !== 16'h0000) begin n_bad++; $display("FAIL rstout_clear: got v=%b s=%h want 0/0000", bus.out_valid, bus.sum_x); end
  endtask

  task automatic test_random();
    int          n;
    bit          use_last;
    int          dly;
    longint      tot;
    logic [15:0] exp_s;
    for (int v = 0; v < 24; v++) begin
      n        = $urandom_range(1, VEC_LEN);
      use_last = (n < VEC_LEN) ? 1'b1 : 1'($urandom);
      for (int i = 0; i < n; i++)
        vec_x[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h1000));
      tot   = vec_total(n);
      exp_s = model_sum(tot);
      push_beats(n, use_last, 1'b1);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.sum_x !== exp_s || bus.out_cnt !== CNT_W'(n) || bus.out_ovf !== (tot > 65535)) begin
        n_bad++;
        $display("FAIL rand_v%0d: got v=%b s=%h c=%0d o=%b want 1/%h/%0d/%b", v, bus.out_valid, bus.sum_x, bus.out_cnt, bus.out_ovf, exp_s, n, tot > 65535);
      end
      dly = $urandom_range(0, 3);
      repeat (dly) @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.sum_x !== exp_s) begin n_bad++; $display("FAIL rand_hold_v%0d: got %b/%h want 1/%h", v, bus.out_valid, bus.sum_x, exp_s); end
      consume();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rand_drop_v%0d: got %b want 0", v, bus.out_valid); end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_x      = 16'h0000;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_four_beats();
    test_single();
    test_full_vector();
    test_zeros();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exp_sum_accum.md
EXP_SUM_ACCUM -- requirements
Module: exp_sum_accum

Interface
REQ-001 SHALL have parameter VEC_LEN, default 64: maximum elements per vector (2..1024).
REQ-002 SHALL have parameter ACC_W, default 22: internal accumulator width in bits (at least 16 + clog2(VEC_LEN)).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: in_x and in_last carry a valid element.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an element this cycle.
REQ-007 SHALL have port in_x, input, 16 bits: unsigned Q4.12 exponential term, typically at most 0x1000 (1.0).
REQ-008 SHALL have port in_last, input, 1 bit: marks the final element of a vector.
REQ-009 SHALL have port out_valid, output, 1 bit: sum_x, out_cnt and out_ovf are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream log2 stage consumes the result.
REQ-011 SHALL have port sum_x, output, 16 bits: unsigned Q4.12 vector sum, never 0, for the log2 stage.
REQ-012 SHALL have port out_cnt, output, clog2(VEC_LEN)+1 bits: number of elements summed.
REQ-013 SHALL have port out_ovf, output, 1 bit: the true sum exceeded 0xFFFF.

Function
REQ-014 SHALL implement three states:
  - IDLE: accumulator is 0, count is 0.
  - ACCUM: at least one element taken.
  - OUT: result held.
REQ-015 SHALL drive in_ready = 1 in IDLE and ACCUM, and 0 in OUT.
REQ-016 SHALL treat an element as accepted only on a cycle where in_valid and in_ready are both 1; the acc is updated as acc + zero-extended in_x and the count is incremented.
REQ-017 SHALL close the vector on the accepted beat that has in_last = 1 or whose count reaches VEC_LEN, whichever comes first; the next state is OUT.
REQ-018 SHALL move from IDLE to ACCUM on an accepted beat that does not close the vector; a closing beat in IDLE goes directly to OUT.
REQ-019 SHALL assert out_valid exactly one cycle after the closing beat, and only in OUT.
REQ-020 SHALL hold sum_x, out_cnt and out_ovf stable while out_valid = 1 and out_ready = 0.
REQ-021 SHALL, when out_valid and out_ready are both 1, return to IDLE, clear acc and count, and deassert out_valid in the next cycle.
REQ-022 SHALL never accept the next vector's first element in the same cycle as the output handshake, because in_ready = 0 in OUT; this gives at most one vector per VEC_LEN+1 cycles.
REQ-023 SHALL set out_ovf = 1 when acc > 0xFFFF at the close of the vector.
REQ-024 SHALL output sum_x = 0x0001 when acc = 0, to guard log2 of zero.
REQ-025 SHALL ignore in_x, in_last and in_valid while in OUT.
REQ-026 SHALL NOT let the accumulator wrap within ACC_W for any legal vector with in_x ≤ 0xFFFF and ACC_W ≥ 16 + clog2(VEC_LEN).

Reset
REQ-027 SHALL, on a cycle with rst = 1, enter IDLE and set acc, count, out_valid, sum_x, out_cnt and out_ovf to 0.
REQ-028 SHALL set in_ready to 1 during reset.
REQ-029 SHALL discard a vector in progress or a pending output on reset mid-operation, with no partial output.
REQ-030 SHALL give rst priority over any simultaneous handshake.

Configuration
REQ-031 SHALL provide macro EXP_SUM_SAT_EN.
REQ-032 SHALL, when EXP_SUM_SAT_EN is defined, output sum_x = 0xFFFF if acc > 0xFFFF, otherwise acc[15:0].
REQ-033 SHALL, when EXP_SUM_SAT_EN is undefined, output sum_x = acc[15:0] (wrap), with out_ovf still reported.
REQ-034 SHALL apply the zero guard of REQ-024 in both builds, including the wrapped case where acc[15:0] = 0.

Verification
REQ-035 SHALL cover: 4 beats of 0x1000 with in_last on beat 4 -> out_valid 1 cycle later; sum_x=0x4000, out_cnt=4, out_ovf=0.
REQ-036 SHALL cover: single beat of 0x0800 with in_last, taken from IDLE -> OUT next cycle; sum_x=0x0800, out_cnt=1.
REQ-037 SHALL cover: VEC_LEN=64, 64 beats of 0x1000 with no in_last -> closes at beat 64; out_ovf=1, out_cnt=64, sum_x=0xFFFF with the macro and 0x0000→0x0001 without it.
REQ-038 SHALL cover: 3 beats of 0x0000 with last -> sum_x=0x0001, out_ovf=0.
REQ-039 SHALL cover: out_ready held low for 5 cycles with in_valid=1 throughout -> in_ready=0 and outputs stable; on out_ready=1, IDLE next cycle and the new vector starts from acc 0.
REQ-040 SHALL cover: rst pulsed after 2 of 4 beats -> no out_valid; a following 2-beat vector of 0x0400 gives sum_x=0x0800, out_cnt=2.
